sliding_puzzle_ctrl: RTL and testbench
======================================

# sliding_puzzle_ctrl

Parametrised ROWS×COLS sliding-tile puzzle engine: holds the live board, applies blank-tile moves from the debounced direction inputs, tracks the blank position and a move counter, and flags the solved arrangement. Sits between the board-select/menu logic (which supplies `game_status` and the starting board) and the display renderer (which consumes `board`). It is the generalised successor of the fixed 2×2 controller. It adds bounds checking, single-cycle move latency, in-game restart and move counting.

## Interface
Parameters:
- ROWS, 2, board rows (≥2)
- COLS, 2, board columns (≥2)
- CW, 8, move-counter width

Derived values:
- N = ROWS*COLS
- TW = max(1, $clog2(N))
- BLANK = N-1

Ports:
- clk_d  in  1  game clock
- reset  in  1  synchronous, active-high
- game_status  in  2  00 LOAD, 01 PLAY, 10 INIT, 11 WON
- act  in  4  direction one-hot for blank: [0] up, [1] right, [2] down, [3] left
- active  in  1  single-cycle move strobe
- restart  in  1  in-game restart to stored origin (PLAY only)
- origin_board  in  N*TW  starting board; cell i = r*COLS+c at [i*TW +: TW]
- board  out  N*TW  live board
- blank_row  out  $clog2(ROWS)  blank row
- blank_col  out  $clog2(COLS)  blank column
- move_count  out  CW  accepted moves since load/restart, saturating
- illegal  out  1  one-cycle pulse, move rejected at edge
- load_error  out  1  stored origin contains no BLANK cell
- win_flag  out  1  board is solved

## Operation
- **Solved layout:** cell i holds i for i<N-1, and cell N-1 holds BLANK.
- **Reset values:**
  - board = solved layout; origin register = solved layout
  - blank = (ROWS-1, COLS-1)
  - move_count = 0
  - illegal = 0, load_error = 0, win_flag = 0
- **LOAD:**
  - Every cycle: origin register ← origin_board.
  - board and count are held.
- **INIT:**
  - board ← origin register; move_count ← 0.
  - Blank ← lowest-index cell whose code is BLANK.
  - load_error ← 1 if no cell holds BLANK. In that case the blank is set to (0,0) and moves are still bounds-checked.
- **PLAY:**
  - restart has priority over active. restart performs the same action as INIT.
  - On active with act≠0, the lowest set bit selects the direction.
  - Target cell = blank position ± 1 row/column.
  - Target outside the board: illegal pulses; board, blank and count are unchanged.
  - Otherwise: swap the BLANK cell and the target cell, blank ← target, move_count += 1 (saturates at 2^CW-1).
  - active with act=0: no action, no illegal pulse.
  - active is ignored when the mode is not PLAY.
- **WON:** board, blank and count are frozen; active and restart are ignored.
- **Win detection:** win_flag ← (board == solved layout), evaluated every cycle regardless of mode.

## Timing
- A move or INIT/restart is visible on board, blank_row/col and move_count on the first edge after it is sampled: 1-cycle latency.
- illegal is asserted for exactly the cycle following the rejected strobe.
- win_flag lags board by one cycle (registered compare).
- Back-to-back active strobes on consecutive cycles are each applied. The second strobe uses the blank position updated by the first.
- A game_status change takes effect on the same edge it is sampled. A strobe sampled together with a PLAY→WON change is dropped.
- reset overrides everything on any edge, including mid-sequence.

## Structure
- Package `sliding_puzzle_pkg`:
  - mode encodings: MODE_LOAD, MODE_PLAY, MODE_INIT, MODE_WON
  - direction bit indices: DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3
- Sub-module `puzzle_blank_locator`:
  - parametrised combinational priority encoder over the N cells
  - returns the row/column of the lowest-index BLANK cell, plus a found flag
  - used by the INIT/restart path

## Test plan
- **Reset, 3×3:** board = solved layout with BLANK = 8, blank = (2,2), win_flag = 1 one cycle after reset; move_count = 0.
- **LOAD then INIT:** LOAD a 2×2 origin {cell0=3, cell1=0, cell2=1, cell3=2}, then INIT → blank = (0,0), count = 0, win_flag = 0.
- **Legal moves:** from the previous state, PLAY with active, act=0010 (right) → cell0=0, cell1=3, blank = (0,1), count = 1. Then act=0100 (down) → blank = (1,1), count = 2.
- **Edge rejection:** blank at (0,0), act=0001 (up) → illegal pulses one cycle; board and count unchanged.
- **Priority and restart:** act=1010 → right is applied. restart together with active → origin restored, count = 0, no move applied.
- **Saturation and WON freeze:** CW=2, four legal moves → count stays at 3. Switching to WON → further strobes leave the board unchanged.

Source files
------------

// File: rtl/sliding_puzzle_pkg.sv
// Shared encodings for the sliding-tile puzzle engine: game modes, direction bits,
// and the tile-code width helper.
package sliding_puzzle_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_PLAY = 2'b01,
    MODE_INIT = 2'b10,
    MODE_WON  = 2'b11
  } mode_e;

  localparam int DIR_UP    = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 3;

  // Bits per tile code; a 1-cell board would otherwise give zero width.
  function automatic int tile_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sliding_puzzle_ctrl_blank_locator.sv
// Combinational priority encoder: row/column of the lowest-index cell holding
// the BLANK code, plus a found flag. Outputs (0,0) when no cell matches.
module puzzle_blank_locator
  import sliding_puzzle_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  localparam int N     = ROWS * COLS,
  localparam int TW    = tile_width(N),
  localparam int RW    = $clog2(ROWS),
  localparam int CLW   = $clog2(COLS),
  localparam int BLANK = N - 1
) (
  input  logic [N*TW-1:0] cells,
  output logic [RW-1:0]   row,
  output logic [CLW-1:0]  col,
  output logic            found
);

  logic [N-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_hit
      assign hit[gi] = (cells[gi*TW +: TW] == TW'(BLANK));
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    found = |hit;
    row   = '0;
    col   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        row = RW'(i / COLS);
        col = CLW'(i % COLS);
      end
    end
  end

endmodule

// File: rtl/sliding_puzzle_ctrl.sv
// ROWS x COLS sliding-tile engine: live board, bounds-checked blank moves,
// saturating move counter, restart to the stored origin and solved detection.
module sliding_puzzle_ctrl
  import sliding_puzzle_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int CW   = 8,
  localparam int N   = ROWS * COLS,
  localparam int TW  = tile_width(N),
  localparam int RW  = $clog2(ROWS),
  localparam int CLW = $clog2(COLS)
) (
  input  logic            clk_d,
  input  logic            reset,
  input  logic [1:0]      game_status,
  input  logic [3:0]      act,
  input  logic            active,
  input  logic            restart,
  input  logic [N*TW-1:0] origin_board,
  output logic [N*TW-1:0] board,
  output logic [RW-1:0]   blank_row,
  output logic [CLW-1:0]  blank_col,
  output logic [CW-1:0]   move_count,
  output logic            illegal,
  output logic            load_error,
  output logic            win_flag
);

  logic [N*TW-1:0] board_reg, board_next;
  logic [N*TW-1:0] origin_reg, origin_next;
  logic [N*TW-1:0] solved_board;
  logic [RW-1:0]   blank_row_reg, blank_row_next;
  logic [CLW-1:0]  blank_col_reg, blank_col_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            illegal_reg, illegal_next;
  logic            load_error_reg, load_error_next;
  logic            win_reg;

  logic [RW-1:0]   loc_row;
  logic [CLW-1:0]  loc_col;
  logic            loc_found;

  mode_e mode;
  logic  do_init, do_move, move_ok;
  int    tgt_row, tgt_col, blank_idx, target_idx;

  assign mode = mode_e'(game_status);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_solved
      assign solved_board[gi*TW +: TW] = TW'(gi);
    end
  endgenerate

  puzzle_blank_locator #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_locator (
    .cells (origin_reg),
    .row   (loc_row),
    .col   (loc_col),
    .found (loc_found)
  );

  // Target cell for the lowest set direction bit; move_ok is the bounds check.
  always_comb begin
    tgt_row = int'(blank_row_reg);
    tgt_col = int'(blank_col_reg);
    move_ok = 1'b0;
    if (act[DIR_UP]) begin
      move_ok = (tgt_row != 0);
      tgt_row = tgt_row - 1;
    end else if (act[DIR_RIGHT]) begin
      move_ok = (tgt_col != COLS - 1);
      tgt_col = tgt_col + 1;
    end else if (act[DIR_DOWN]) begin
      move_ok = (tgt_row != ROWS - 1);
      tgt_row = tgt_row + 1;
    end else if (act[DIR_LEFT]) begin
      move_ok = (tgt_col != 0);
      tgt_col = tgt_col - 1;
    end
    blank_idx  = int'(blank_row_reg) * COLS + int'(blank_col_reg);
    target_idx = move_ok ? (tgt_row * COLS + tgt_col) : blank_idx;
  end

  always_comb begin
    do_init = 1'b0;
    do_move = 1'b0;
    origin_next = origin_reg;
    case (mode)
      MODE_LOAD: origin_next = origin_board;
      MODE_INIT: do_init = 1'b1;
      MODE_PLAY: begin
        if (restart)
          do_init = 1'b1;
        else if (active && (act != 4'd0))
          do_move = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    board_next      = board_reg;
    blank_row_next  = blank_row_reg;
    blank_col_next  = blank_col_reg;
    count_next      = count_reg;
    load_error_next = load_error_reg;
    illegal_next    = 1'b0;
    if (do_init) begin
      board_next      = origin_reg;
      count_next      = '0;
      load_error_next = !loc_found;
      blank_row_next  = loc_row;
      blank_col_next  = loc_col;
    end else if (do_move) begin
      if (!move_ok) begin
        illegal_next = 1'b1;
      end else begin
        board_next[blank_idx*TW +: TW]  = board_reg[target_idx*TW +: TW];
        board_next[target_idx*TW +: TW] = board_reg[blank_idx*TW +: TW];
        blank_row_next = RW'(tgt_row);
        blank_col_next = CLW'(tgt_col);
        if (count_reg != {CW{1'b1}})
          count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_d) begin
    if (reset) begin
      board_reg      <= solved_board;
      origin_reg     <= solved_board;
      blank_row_reg  <= RW'(ROWS - 1);
      blank_col_reg  <= CLW'(COLS - 1);
      count_reg      <= '0;
      illegal_reg    <= 1'b0;
      load_error_reg <= 1'b0;
      win_reg        <= 1'b0;
    end else begin
      board_reg      <= board_next;
      origin_reg     <= origin_next;
      blank_row_reg  <= blank_row_next;
      blank_col_reg  <= blank_col_next;
      count_reg      <= count_next;
      illegal_reg    <= illegal_next;
      load_error_reg <= load_error_next;
      win_reg        <= (board_reg == solved_board);
    end
  end

  assign board      = board_reg;
  assign blank_row  = blank_row_reg;
  assign blank_col  = blank_col_reg;
  assign move_count = count_reg;
  assign illegal    = illegal_reg;
  assign load_error = load_error_reg;
  assign win_flag   = win_reg;

endmodule

// File: tb/tb_sliding_puzzle_ctrl.sv
// Directed bench: a 3x3 instance for reset/indexing checks and a 2x2 CW=2 instance
// tracked by a behavioural model whose expectations pass through a scoreboard queue.
module tb_sliding_puzzle_ctrl;
  import sliding_puzzle_pkg::*;

  logic clk_d = 1'b0;
  always #5 clk_d = ~clk_d;
  logic reset;

  logic [1:0]  gs_a;
  logic [3:0]  act_a;
  logic        active_a, restart_a;
  logic [35:0] origin_a, board_a;
  logic [1:0]  br_a, bc_a;
  logic [7:0]  cnt_a;
  logic        ill_a, lerr_a, win_a;

  logic [1:0]  gs_b;
  logic [3:0]  act_b;
  logic        active_b, restart_b;
  logic [7:0]  origin_b, board_b;
  logic        br_b, bc_b;
  logic [1:0]  cnt_b;
  logic        ill_b, lerr_b, win_b;

  sliding_puzzle_ctrl #(.ROWS(3), .COLS(3), .CW(8)) dut_a (
    .clk_d(clk_d), .reset(reset), .game_status(gs_a), .act(act_a), .active(active_a),
    .restart(restart_a), .origin_board(origin_a), .board(board_a), .blank_row(br_a),
    .blank_col(bc_a), .move_count(cnt_a), .illegal(ill_a), .load_error(lerr_a),
    .win_flag(win_a)
  );

  sliding_puzzle_ctrl #(.ROWS(2), .COLS(2), .CW(2)) dut_b (
    .clk_d(clk_d), .reset(reset), .game_status(gs_b), .act(act_b), .active(active_b),
    .restart(restart_b), .origin_board(origin_b), .board(board_b), .blank_row(br_b),
    .blank_col(bc_b), .move_count(cnt_b), .illegal(ill_b), .load_error(lerr_b),
    .win_flag(win_b)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] board;
    logic       br;
    logic       bc;
    logic [1:0] cnt;
    logic       ill;
    logic       lerr;
    logic       win;
  } exp_t;
  exp_t sb[$];

  int m_board[4];
  int m_origin[4];
  int m_br, m_bc, m_cnt;
  bit m_ill, m_lerr, m_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_packed();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) v[i*2 +: 2] = 2'(m_board[i]);
    return v;
  endfunction

  task automatic model_init();
    bit found;
    found = 1'b0;
    m_br = 0;
    m_bc = 0;
    for (int i = 0; i < 4; i++) begin
      m_board[i] = m_origin[i];
      if (!found && m_origin[i] == 3) begin
        found = 1'b1;
        m_br = i / 2;
        m_bc = i % 2;
      end
    end
    m_lerr = !found;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit rst);
    int nr, nc, b, t, tmp;
    bit sol;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_board[i] = i;
        m_origin[i] = i;
      end
      m_br = 1; m_bc = 1; m_cnt = 0; m_ill = 0; m_lerr = 0; m_win = 0;
      return;
    end
    sol = 1'b1;
    for (int i = 0; i < 4; i++) if (m_board[i] != i) sol = 1'b0;
    m_win = sol;
    m_ill = 1'b0;
    case (gs_b)
      2'b00: for (int i = 0; i < 4; i++) m_origin[i] = int'(origin_b[i*2 +: 2]);
      2'b10: model_init();
      2'b01: begin
        if (restart_b) model_init();
        else if (active_b && act_b != 4'd0) begin
          nr = m_br; nc = m_bc;
          if (act_b[0]) nr--;
          else if (act_b[1]) nc++;
          else if (act_b[2]) nr++;
          else nc--;
          if (nr < 0 || nr > 1 || nc < 0 || nc > 1) m_ill = 1'b1;
          else begin
            b = m_br * 2 + m_bc;
            t = nr * 2 + nc;
            tmp = m_board[b]; m_board[b] = m_board[t]; m_board[t] = tmp;
            m_br = nr; m_bc = nc;
            if (m_cnt < 3) m_cnt++;
          end
        end
      end
      default: ;
    endcase
  endtask

  // One clocked transaction on instance B: drive, predict, then compare one edge later.
  task automatic step(input string lbl, input bit rst, input logic [1:0] gs,
                      input logic [3:0] act, input bit act_v, input bit rs);
    exp_t e;
    reset = rst; gs_b = gs; act_b = act; active_b = act_v; restart_b = rs;
    model_step(rst);
    e.board = m_packed(); e.br = 1'(m_br); e.bc = 1'(m_bc); e.cnt = 2'(m_cnt);
    e.ill = m_ill; e.lerr = m_lerr; e.win = m_win;
    sb.push_back(e);
    @(posedge clk_d);
    #1;
    e = sb.pop_front();
    chk({lbl, ".board"}, board_b, e.board);
    chk({lbl, ".blank_row"}, br_b, e.br);
    chk({lbl, ".blank_col"}, bc_b, e.bc);
    chk({lbl, ".count"}, cnt_b, e.cnt);
    chk({lbl, ".illegal"}, ill_b, e.ill);
    chk({lbl, ".load_error"}, lerr_b, e.lerr);
    chk({lbl, ".win"}, win_b, e.win);
    $display("step %-14s board=%h blank=(%0d,%0d) count=%0d illegal=%0b win=%0b",
             lbl, board_b, br_b, bc_b, cnt_b, ill_b, win_b);
  endtask

  logic [35:0] solved_a, exp_up_a;

  initial begin
    for (int i = 0; i < 9; i++) solved_a[i*4 +: 4] = 4'(i);
    exp_up_a = solved_a;
    exp_up_a[8*4 +: 4] = 4'd5;
    exp_up_a[5*4 +: 4] = 4'd8;
    reset = 1'b1;
    gs_a = MODE_LOAD; act_a = 4'd0; active_a = 1'b0; restart_a = 1'b0; origin_a = solved_a;
    gs_b = MODE_LOAD; act_b = 4'd0; active_b = 1'b0; restart_b = 1'b0; origin_b = 8'he4;

    step("rst0", 1'b1, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    step("rst1", 1'b1, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    chk("a_rst.board", board_a, solved_a);
    chk("a_rst.blank_row", br_a, 2'd2);
    chk("a_rst.blank_col", bc_a, 2'd2);
    chk("a_rst.count", cnt_a, 8'd0);
    chk("a_rst.win", win_a, 1'b0);
    chk("a_rst.load_error", lerr_a, 1'b0);

    step("idle", 1'b0, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    chk("a_win_after_reset", win_a, 1'b1);

    gs_a = MODE_INIT;
    step("a_init", 1'b0, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    chk("a_init.blank_row", br_a, 2'd2);
    gs_a = MODE_PLAY; active_a = 1'b1; act_a = 4'b0001;
    step("a_up", 1'b0, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    chk("a_up.board", board_a, exp_up_a);
    chk("a_up.blank_row", br_a, 2'd1);
    chk("a_up.blank_col", bc_a, 2'd2);
    chk("a_up.count", cnt_a, 8'd1);
    act_a = 4'b0010;
    step("a_right_edge", 1'b0, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    chk("a_right_edge.illegal", ill_a, 1'b1);
    chk("a_right_edge.board", board_a, exp_up_a);
    chk("a_right_edge.count", cnt_a, 8'd1);
    active_a = 1'b0;
    step("a_idle", 1'b0, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    chk("a_idle.illegal", ill_a, 1'b0);
    chk("a_idle.win", win_a, 1'b0);

    origin_b = 8'h93;
    step("b_load", 1'b0, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    step("b_init", 1'b0, MODE_INIT, 4'd0, 1'b0, 1'b0);
    chk("b_init.board", board_b, 8'h93);
    chk("b_init.blank", {br_b, bc_b}, 2'b00);
    step("b_init_win", 1'b0, MODE_PLAY, 4'd0, 1'b0, 1'b0);
    chk("b_init_win.win", win_b, 1'b0);
    step("b_right", 1'b0, MODE_PLAY, 4'b0010, 1'b1, 1'b0);
    chk("b_right.board", board_b, 8'h9c);
    chk("b_right.blank", {br_b, bc_b}, 2'b01);
    step("b_down", 1'b0, MODE_PLAY, 4'b0100, 1'b1, 1'b0);
    chk("b_down.board", board_b, 8'hd8);
    chk("b_down.count", cnt_b, 2'd2);
    step("b_restart", 1'b0, MODE_PLAY, 4'd0, 1'b0, 1'b1);
    step("b_up_edge", 1'b0, MODE_PLAY, 4'b0001, 1'b1, 1'b0);
    chk("b_up_edge.illegal", ill_b, 1'b1);
    chk("b_up_edge.board", board_b, 8'h93);
    step("b_idle", 1'b0, MODE_PLAY, 4'd0, 1'b0, 1'b0);
    step("b_prio", 1'b0, MODE_PLAY, 4'b1010, 1'b1, 1'b0);
    chk("b_prio.board", board_b, 8'h9c);
    step("b_restart_act", 1'b0, MODE_PLAY, 4'b0100, 1'b1, 1'b1);
    chk("b_restart_act.board", board_b, 8'h93);
    step("b_sat_r", 1'b0, MODE_PLAY, 4'b0010, 1'b1, 1'b0);
    step("b_sat_d", 1'b0, MODE_PLAY, 4'b0100, 1'b1, 1'b0);
    step("b_sat_l", 1'b0, MODE_PLAY, 4'b1000, 1'b1, 1'b0);
    step("b_sat_u", 1'b0, MODE_PLAY, 4'b0001, 1'b1, 1'b0);
    chk("b_sat_u.count", cnt_b, 2'd3);
    chk("b_sat_u.board", board_b, 8'h4b);
    step("b_sat_r2", 1'b0, MODE_PLAY, 4'b0010, 1'b1, 1'b0);
    step("b_act0", 1'b0, MODE_PLAY, 4'd0, 1'b1, 1'b0);
    step("b_won_mv", 1'b0, MODE_WON, 4'b0100, 1'b1, 1'b0);
    step("b_won_rst", 1'b0, MODE_WON, 4'd0, 1'b0, 1'b1);

    origin_b = 8'h00;
    step("b_load_err", 1'b0, MODE_LOAD, 4'd0, 1'b0, 1'b0);
    step("b_init_err", 1'b0, MODE_INIT, 4'd0, 1'b0, 1'b0);
    chk("b_init_err.load_error", lerr_b, 1'b1);
    step("b_err_up", 1'b0, MODE_PLAY, 4'b0001, 1'b1, 1'b0);
    step("b_err_right", 1'b0, MODE_PLAY, 4'b0010, 1'b1, 1'b0);
    step("b_reset_mid", 1'b1, MODE_PLAY, 4'b0100, 1'b1, 1'b0);
    chk("b_reset_mid.board", board_b, 8'he4);
    step("b_after_rst", 1'b0, MODE_PLAY, 4'd0, 1'b0, 1'b0);
    chk("b_after_rst.win", win_b, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
